// File: rtl/period_chk_pkg.sv
// Shared state encoding and default timing constants for the tick-period checker.
// Pure declarations: no latency, no flow control.
package period_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam int DEF_MIN_DLY = 3;
  localparam int DEF_TYP_DLY = 10;
  localparam int DEF_MAX_DLY = 15;
  localparam int DEF_CW      = 8;
  localparam int EVT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: count updates on the edge where inc is high, sticks at all-ones.
// No backpressure; inc is sampled every cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/period_checker.sv
// Classifies the interval between sampled ticks as early/ok/typ/late; pulses and last_period one cycle after the deciding edge.
// No backpressure: tick is observed every cycle, enable low parks the checker in IDLE.
module period_checker
  import period_chk_pkg::*;
#(
  parameter int MIN_DLY = DEF_MIN_DLY,
  parameter int TYP_DLY = DEF_TYP_DLY,
  parameter int MAX_DLY = DEF_MAX_DLY,
  parameter int CW      = DEF_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  output logic             ok_pulse,
  output logic             early_pulse,
  output logic             late_pulse,
  output logic             typ_pulse,
  output logic [CW-1:0]    last_period,
  output logic [EVT_W-1:0] ok_count,
  output logic [EVT_W-1:0] err_count
);

  if (MIN_DLY > TYP_DLY) begin : g_bad_min
    $error("period_checker: MIN_DLY must not exceed TYP_DLY");
  end
  if (TYP_DLY > MAX_DLY) begin : g_bad_typ
    $error("period_checker: TYP_DLY must not exceed MAX_DLY");
  end
  if ((MAX_DLY + 1) >= (1 << CW)) begin : g_bad_cw
    $error("period_checker: MAX_DLY+1 does not fit below 2^CW");
  end

  localparam logic [CW-1:0] MIN_V  = CW'(MIN_DLY);
  localparam logic [CW-1:0] TYP_V  = CW'(TYP_DLY);
  localparam logic [CW-1:0] LATE_V = CW'(MAX_DLY + 1);
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] period_nxt;
  logic          ok_nxt, early_nxt, late_nxt, typ_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last_period <= '0;
      ok_pulse    <= 1'b0;
      early_pulse <= 1'b0;
      late_pulse  <= 1'b0;
      typ_pulse   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last_period <= period_nxt;
      ok_pulse    <= ok_nxt;
      early_pulse <= early_nxt;
      late_pulse  <= late_nxt;
      typ_pulse   <= typ_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = last_period;
    ok_nxt     = 1'b0;
    early_nxt  = 1'b0;
    late_nxt   = 1'b0;
    typ_nxt    = 1'b0;
    // Dropping enable wins over a coincident tick.
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: state_nxt = ARMED;
        ARMED, TIMEOUT: begin
          if (tick) begin
            state_nxt = MEASURE;
            cnt_nxt   = ONE_V;
          end
        end
        MEASURE: begin
          // The MAX_DLY+1 boundary is late even if a tick lands on it.
          if (cnt == LATE_V) begin
            late_nxt   = 1'b1;
            period_nxt = LATE_V;
            state_nxt  = TIMEOUT;
          end else if (tick) begin
            early_nxt  = (cnt < MIN_V);
            ok_nxt     = !(cnt < MIN_V);
            typ_nxt    = !(cnt < MIN_V) && (cnt == TYP_V);
            period_nxt = cnt;
            cnt_nxt    = ONE_V;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + ONE_V;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  sat_counter #(.W(EVT_W)) u_ok_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ok_nxt),
    .count (ok_count)
  );

  sat_counter #(.W(EVT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (early_nxt | late_nxt),
    .count (err_count)
  );

endmodule
